pwm_gen: RTL and testbench
==========================

# pwm_gen

Programmable PWM generator. It produces a rectangular output whose period and high time are set in clk cycles. It is the transmit-side counterpart of the duty/period measurement logic in the freq FPGA design: a pwm_out generated with period P and high time H, looped back into the measurement block, must read back as P and H. It sits between the register/bus interface (which supplies the settings) and an output pin or internal loopback.

## Interface
- WIDTH, 32, width of the period/high counters and settings.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  level; high = generate, low = stop after the current period.
- load  in  1  single-cycle strobe; captures period_in/high_in into the shadow registers.
- period_in  in  WIDTH  period in clk cycles; legal range ≥ 2.
- high_in  in  WIDTH  high time in clk cycles; 0 = always low, ≥ period = always high.
- burst_len  in  WIDTH  number of periods per burst (only with PWM_GEN_BURST_EN).
- pwm_out  out  1  registered PWM output.
- cycle_start  out  1  one-cycle pulse coincident with the first cycle of each period.
- busy  out  1  high while state ≠ IDLE.
- cfg_err  out  1  sticky; set by a load with period_in < 2; cleared by the next legal load.
- burst_done  out  1  one-cycle pulse after the last burst period (only with PWM_GEN_BURST_EN).

## Operation
- Shadow registers: period_sh and high_sh, reset to 2 and 0.
  - A legal load writes period_in and high_in into them.
  - An illegal load (period_in < 2) leaves them unchanged and sets cfg_err.
- Active registers: period_act and high_act. They are copied from the shadows only at a period boundary (wrap) or when leaving IDLE, so no output period is ever truncated.
  - A legal load on the same edge as a wrap or IDLE→RUN bypasses the shadows: the new values apply to the period starting at that edge.
- cnt counts 0 … period_act−1 and then wraps to 0.
- pwm_out is the registered value of (cnt_next < high_act_next).
  - The high time is exactly min(high_act, period_act) cycles per period, starting at cnt = 0.
- State machine:
  - IDLE: cnt = 0, pwm_out = 0. enable = 1 → RUN.
  - RUN: counts continuously. enable = 0 sampled at any point → STOP.
  - STOP: keeps counting to the end of the current period. At the wrap → IDLE, pwm_out = 0. enable reasserted before the wrap → back to RUN with no gap.
- cfg_err does not affect generation.
- Arithmetic is unsigned WIDTH bits. The comparison cnt == period_act−1 decides the wrap, so no overflow is possible with period ≥ 2.

## Timing
- Reset values: pwm_out 0, cycle_start 0, busy 0, cfg_err 0, burst_done 0; cnt 0; state IDLE.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Shadow registers also reset.
- Start latency: enable sampled high at edge N. At edge N, cnt becomes 0, pwm_out becomes (high ≠ 0), cycle_start becomes 1, busy becomes 1. The first period therefore appears 1 cycle after enable.
- cycle_start is high for exactly one cycle every period_act cycles while in RUN or STOP.
- After a load, new settings take effect at the next wrap: latency ≤ period_act cycles.
- Stop: busy falls and pwm_out is 0 on the edge that completes the last full period.

## Configuration
- PWM_GEN_BURST_EN defined:
  - The burst_len input and burst_done output exist.
  - burst_len is sampled on IDLE→RUN (0 is treated as 1).
  - After burst_len complete periods the block enters IDLE and pulses burst_done for one cycle on that edge.
  - enable must return low and then high again to start a new burst. It is edge-triggered in this mode, so enable held high does not retrigger.
- PWM_GEN_BURST_EN undefined:
  - Neither port exists.
  - Generation is continuous while enable is high.

## Structure
- Shared package pwm_pkg holds:
  - the state enum (IDLE, RUN, STOP);
  - default WIDTH constant 32;
  - MIN_PERIOD constant 2.
- One sub-module, pwm_gen_cnt: the period counter with the wrap compare and the cnt_next/wrap outputs. The top level holds the shadow/active registers, the FSM and the burst counter.

## Test plan
- Reset, then load P = 10, H = 3, enable = 1 → pwm_out high 3 cycles, low 7, repeating; cycle_start every 10 cycles; first rise 1 cycle after enable.
- While running P = 10/H = 3, load P = 4, H = 1 mid-period → current period completes as 10/3, then 4/1 from the next cycle_start with no glitch.
- Edge settings: H = 0 → pwm_out constant 0. H = 10 with P = 10 → constant 1. H = 15 with P = 10 → constant 1. cycle_start still pulses every 10 cycles.
- Load P = 1 → cfg_err = 1 and output unchanged; then load P = 6, H = 2 → cfg_err = 0 and 6/2 applies at the next wrap.
- Drop enable at cnt = 4 of a P = 10 period → output completes the period, busy falls at the wrap; assert reset mid-period → pwm_out = 0 immediately.
- With PWM_GEN_BURST_EN, burst_len = 3, P = 5, H = 2 → exactly 3 pulses, then burst_done for one cycle, busy = 0; enable held high does not retrigger.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM generator.
//   state_t       FSM state encoding (IDLE, RUN, STOP)
//   DEFAULT_WIDTH default width of the period/high counters and settings
//   MIN_PERIOD    smallest legal period in clk cycles
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int MIN_PERIOD    = 2;

endpackage

// File: rtl/pwm_gen_cnt.sv
// pwm_gen_cnt: period counter for pwm_gen.
//   clk, reset  clock, asynchronous active-low reset
//   active      high while the generator is outside IDLE; low holds the count at 0
//   period_act  period currently being generated
//   cnt_next    value the counter takes at the next edge
//   wrap        high in the last cycle of a period (cnt == period_act-1)
module pwm_gen_cnt
   import pwm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             active,
   input  logic [WIDTH-1:0] period_act,
   output logic [WIDTH-1:0] cnt_next,
   output logic             wrap
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Equality against period-1 rather than a >= test: with period >= 2 the
   // count can never pass the terminal value, so no overflow handling is needed.
   always_comb begin
      wrap  = active && (cnt_q == (period_act - WIDTH'(1)));
      cnt_d = cnt_q + WIDTH'(1);
      if (!active || wrap) begin
         cnt_d = '0;
      end
   end

   assign cnt_next = cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: programmable PWM generator (period and high time in clk cycles).
//   clk, reset        clock, asynchronous active-low reset
//   enable            level; high = generate, low = stop after the current period
//   load              strobe capturing period_in/high_in into the shadow registers
//   period_in/high_in requested period (>= 2) and high time
//   pwm_out           registered PWM output
//   cycle_start       one-cycle pulse on the first cycle of every period
//   busy              high while not IDLE
//   cfg_err           sticky flag for a load with period_in < 2
// Optional build macro PWM_GEN_BURST_EN adds burst_len/burst_done: a rising
// enable runs burst_len periods (0 counts as 1) then returns to IDLE.
//
// state | meaning
// IDLE  | output low, counter held at 0, waiting for enable
// RUN   | generating periods back to back
// STOP  | enable dropped; finishing the current period, then IDLE
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] period_in,
   input  logic [WIDTH-1:0] high_in,
`ifdef PWM_GEN_BURST_EN
   input  logic [WIDTH-1:0] burst_len,
   output logic             burst_done,
`endif
   output logic             pwm_out,
   output logic             cycle_start,
   output logic             busy,
   output logic             cfg_err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] period_sh_q, period_sh_d, high_sh_q, high_sh_d;
   logic [WIDTH-1:0] period_act_q, period_act_d, high_act_q, high_act_d;
   logic             pwm_q, pwm_d, cycle_start_q, cycle_start_d, cfg_err_q, cfg_err_d;
   logic [WIDTH-1:0] cnt_next;
   logic             active, wrap, load_ok, trigger, last_period, start, reload;

`ifdef PWM_GEN_BURST_EN
   logic [WIDTH-1:0] burst_rem_q, burst_rem_d;
   logic             armed_q, armed_d, burst_done_q, burst_done_d;

   // armed_q makes burst start edge-triggered: it is only set again once
   // enable has been seen low while idle.
   assign trigger     = enable && armed_q;
   assign last_period = (burst_rem_q == WIDTH'(1));
   assign burst_done  = burst_done_q;
`else
   assign trigger     = enable;
   assign last_period = 1'b0;
`endif

   assign active = (state_q != IDLE);

   pwm_gen_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .active     (active),
      .period_act (period_act_q),
      .cnt_next   (cnt_next),
      .wrap       (wrap)
   );

   always_comb begin
      load_ok     = load && (period_in >= WIDTH'(MIN_PERIOD));
      period_sh_d = load_ok ? period_in : period_sh_q;
      high_sh_d   = load_ok ? high_in : high_sh_q;
      cfg_err_d   = load ? !load_ok : cfg_err_q;

      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = RUN;
               start   = 1'b1;
            end
         end
         RUN, STOP: begin
            if (wrap) begin
               if (enable && !last_period) state_d = RUN;
               else                        state_d = IDLE;
            end else if (enable) begin
               state_d = RUN;
            end else begin
               state_d = STOP;
            end
         end
         default: state_d = IDLE;
      endcase

      // The active settings come from the *next* shadow value so that a load
      // on a boundary edge applies to the period starting at that edge.
      reload        = start || (wrap && (state_d != IDLE));
      period_act_d  = reload ? period_sh_d : period_act_q;
      high_act_d    = reload ? high_sh_d : high_act_q;
      pwm_d         = (state_d != IDLE) && (cnt_next < high_act_d);
      cycle_start_d = reload;

`ifdef PWM_GEN_BURST_EN
      armed_d = armed_q;
      if ((state_q == IDLE) && !enable) armed_d = 1'b1;
      else if (start)                   armed_d = 1'b0;
      burst_rem_d = burst_rem_q;
      if (start)     burst_rem_d = (burst_len == '0) ? WIDTH'(1) : burst_len;
      else if (wrap) burst_rem_d = burst_rem_q - WIDTH'(1);
      burst_done_d = wrap && last_period;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         period_sh_q   <= WIDTH'(MIN_PERIOD);
         high_sh_q     <= '0;
         period_act_q  <= WIDTH'(MIN_PERIOD);
         high_act_q    <= '0;
         pwm_q         <= 1'b0;
         cycle_start_q <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         period_sh_q   <= period_sh_d;
         high_sh_q     <= high_sh_d;
         period_act_q  <= period_act_d;
         high_act_q    <= high_act_d;
         pwm_q         <= pwm_d;
         cycle_start_q <= cycle_start_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

`ifdef PWM_GEN_BURST_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         burst_rem_q  <= '0;
         armed_q      <= 1'b1;
         burst_done_q <= 1'b0;
      end else begin
         burst_rem_q  <= burst_rem_d;
         armed_q      <= armed_d;
         burst_done_q <= burst_done_d;
      end
   end
`endif

   assign pwm_out     = pwm_q;
   assign cycle_start = cycle_start_q;
   assign busy        = (state_q != IDLE);
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen. A period-level reference model
// (position within the period, active/shadow settings) predicts every output.
module tb_pwm_gen;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] period_in = '0;
   logic [W-1:0] high_in = '0;
   logic         pwm_out, cycle_start, busy, cfg_err;
`ifdef PWM_GEN_BURST_EN
   logic [W-1:0] burst_len = 32'd1000;
   logic         burst_done;
`endif

   int total = 0;
   int bad = 0;

   // reference model state
   int m_pos, m_p, m_h, sh_p, sh_h, m_rem;
   bit m_busy, m_cs, m_err, m_done, m_armed;

   always #5 clk = ~clk;

   pwm_gen #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .load        (load),
      .period_in   (period_in),
      .high_in     (high_in),
`ifdef PWM_GEN_BURST_EN
      .burst_len   (burst_len),
      .burst_done  (burst_done),
`endif
      .pwm_out     (pwm_out),
      .cycle_start (cycle_start),
      .busy        (busy),
      .cfg_err     (cfg_err)
   );

   task automatic model_reset();
      sh_p = 2; sh_h = 0; m_p = 2; m_h = 0; m_pos = 0; m_rem = 0;
      m_busy = 0; m_cs = 0; m_err = 0; m_done = 0; m_armed = 1;
   endtask

   // One clock edge of the reference model, using the inputs the DUT samples.
   task automatic model_edge();
      bit ok, go, last;
      ok = load && (period_in >= 2);
      if (load) m_err = !ok;
      if (ok) begin
         sh_p = int'(period_in);
         sh_h = int'(high_in);
      end
      m_cs = 0;
      m_done = 0;
      if (!m_busy) begin
         go = enable;
`ifdef PWM_GEN_BURST_EN
         go = enable && m_armed;
         if (!enable) m_armed = 1;
         if (go) begin
            m_armed = 0;
            m_rem = (burst_len == 0) ? 1 : int'(burst_len);
         end
`endif
         if (go) begin
            m_busy = 1; m_pos = 0; m_p = sh_p; m_h = sh_h; m_cs = 1;
         end
      end else if (m_pos == m_p - 1) begin
         last = 0;
`ifdef PWM_GEN_BURST_EN
         m_rem--;
         last = (m_rem == 0);
         m_done = last;
`endif
         if (enable && !last) begin
            m_pos = 0; m_p = sh_p; m_h = sh_h; m_cs = 1;
         end else begin
            m_busy = 0; m_pos = 0;
         end
      end else begin
         m_pos++;
      end
   endtask

   // Advance one clock; returns on the falling edge, where outputs are sampled
   // and new inputs are driven.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({pwm_out, cycle_start, busy, cfg_err} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_values: got %b want 0000", {pwm_out, cycle_start, busy, cfg_err});
      end
      reset = 1'b1;
      model_reset();
      step();
      total++;
      if ({pwm_out, cycle_start, busy, cfg_err} !== {m_busy && (m_pos < m_h), m_cs, m_busy, m_err}) begin
         bad++;
         $display("FAIL reset_idle: got %b want %b", {pwm_out, cycle_start, busy, cfg_err},
                  {m_busy && (m_pos < m_h), m_cs, m_busy, m_err});
      end
   endtask

   task automatic test_basic();
      int highs, starts;
      highs = 0; starts = 0;
      period_in = 10; high_in = 3; load = 1'b1; step(); load = 1'b0;
      enable = 1'b1; step();
      total++;
      if (pwm_out !== 1'b1 || cycle_start !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_first_rise: got pwm=%b cs=%b busy=%b want 1 1 1", pwm_out, cycle_start, busy);
      end
      for (int i = 0; i < 30; i++) begin
         highs += int'(pwm_out);
         starts += int'(cycle_start);
         total++;
         if ({pwm_out, cycle_start, busy, cfg_err} !== {m_busy && (m_pos < m_h), m_cs, m_busy, m_err}) begin
            bad++;
            $display("FAIL basic_cycle %0d: got %b want %b", i, {pwm_out, cycle_start, busy, cfg_err},
                     {m_busy && (m_pos < m_h), m_cs, m_busy, m_err});
         end
         step();
      end
      total++;
      if (highs != 9 || starts != 3) begin
         bad++;
         $display("FAIL basic_counts: got highs=%0d starts=%0d want 9 3", highs, starts);
      end
   endtask

   task automatic test_reload();
      int k, highs, starts;
      k = 0; highs = 0; starts = 0;
      repeat (4) step();
      period_in = 4; high_in = 1; load = 1'b1; step(); load = 1'b0;
      while (cycle_start !== 1'b1 && k < 20) begin
         total++;
         if (pwm_out !== 1'b0) begin
            bad++;
            $display("FAIL reload_tail_low: got pwm=%b want 0", pwm_out);
         end
         step();
         k++;
      end
      total++;
      if (k != 5) begin
         bad++;
         $display("FAIL reload_latency: got %0d cycles want 5", k);
      end
      for (int i = 0; i < 8; i++) begin
         highs += int'(pwm_out);
         starts += int'(cycle_start);
         total++;
         if ({pwm_out, cycle_start, busy, cfg_err} !== {m_busy && (m_pos < m_h), m_cs, m_busy, m_err}) begin
            bad++;
            $display("FAIL reload_cycle %0d: got %b want %b", i, {pwm_out, cycle_start, busy, cfg_err},
                     {m_busy && (m_pos < m_h), m_cs, m_busy, m_err});
         end
         step();
      end
      total++;
      if (highs != 2 || starts != 2) begin
         bad++;
         $display("FAIL reload_counts: got highs=%0d starts=%0d want 2 2", highs, starts);
      end
   endtask

   task automatic test_edge_high();
      int hs[3];
      int k, highs, starts, want;
      hs = '{0, 10, 15};
      for (int t = 0; t < 3; t++) begin
         k = 0; highs = 0; starts = 0;
         period_in = 10; high_in = hs[t]; load = 1'b1; step(); load = 1'b0;
         while (cycle_start !== 1'b1 && k < 20) begin
            step();
            k++;
         end
         total++;
         if (k >= 20) begin
            bad++;
            $display("FAIL edge_wait h=%0d: got no cycle_start within 20 cycles want one", hs[t]);
         end
         for (int i = 0; i < 20; i++) begin
            highs += int'(pwm_out);
            starts += int'(cycle_start);
            step();
         end
         want = (hs[t] == 0) ? 0 : 20;
         total++;
         if (highs != want || starts != 2) begin
            bad++;
            $display("FAIL edge_counts h=%0d: got highs=%0d starts=%0d want %0d 2", hs[t], highs, starts, want);
         end
      end
   endtask

   task automatic test_cfg_err();
      int k, highs, starts;
      k = 0; highs = 0; starts = 0;
      period_in = 1; high_in = 3; load = 1'b1; step(); load = 1'b0;
      total++;
      if (cfg_err !== 1'b1) begin
         bad++;
         $display("FAIL cfg_err_set: got %b want 1", cfg_err);
      end
      for (int i = 0; i < 20; i++) begin
         highs += int'(pwm_out);
         step();
      end
      total++;
      if (highs != 20) begin
         bad++;
         $display("FAIL cfg_err_output_kept: got highs=%0d want 20", highs);
      end
      period_in = 6; high_in = 2; load = 1'b1; step(); load = 1'b0;
      total++;
      if (cfg_err !== 1'b0) begin
         bad++;
         $display("FAIL cfg_err_clear: got %b want 0", cfg_err);
      end
      while (cycle_start !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      for (int i = 0; i < 12; i++) begin
         highs += int'(pwm_out);
         starts += int'(cycle_start);
         step();
      end
      total++;
      if (highs != 24 || starts != 2 || k >= 20) begin
         bad++;
         $display("FAIL cfg_err_new_setting: got highs=%0d starts=%0d wait=%0d want 4 2 <20",
                  highs - 20, starts, k);
      end
   endtask

   task automatic test_stop();
      int k;
      k = 0;
      period_in = 10; high_in = 3; load = 1'b1; step(); load = 1'b0;
      while (cycle_start !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      repeat (4) step();
      enable = 1'b0;
      step();
      k = 0;
      while (busy === 1'b1 && k < 20) begin
         total++;
         if ({pwm_out, cycle_start, busy, cfg_err} !== {m_busy && (m_pos < m_h), m_cs, m_busy, m_err}) begin
            bad++;
            $display("FAIL stop_cycle %0d: got %b want %b", k, {pwm_out, cycle_start, busy, cfg_err},
                     {m_busy && (m_pos < m_h), m_cs, m_busy, m_err});
         end
         step();
         k++;
      end
      total++;
      if (k != 5 || pwm_out !== 1'b0 || cycle_start !== 1'b0) begin
         bad++;
         $display("FAIL stop_at_wrap: got %0d cycles pwm=%b cs=%b want 5 0 0", k, pwm_out, cycle_start);
      end
   endtask

   task automatic test_reset_mid();
      int highs, starts;
      highs = 0; starts = 0;
      period_in = 10; high_in = 5; load = 1'b1; step();
      period_in = 0; enable = 1'b1; step(); load = 1'b0;
      total++;
      if (pwm_out !== 1'b1 || cfg_err !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_setup: got pwm=%b err=%b want 1 1", pwm_out, cfg_err);
      end
      step(); step();
      #2 reset = 1'b0;
      #1;
      total++;
      if ({pwm_out, cycle_start, busy, cfg_err} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_mid_async: got %b want 0000", {pwm_out, cycle_start, busy, cfg_err});
      end
      model_reset();
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         highs += int'(pwm_out);
         starts += int'(cycle_start);
         total++;
         if ({pwm_out, cycle_start, busy, cfg_err} !== {m_busy && (m_pos < m_h), m_cs, m_busy, m_err}) begin
            bad++;
            $display("FAIL reset_mid_cycle %0d: got %b want %b", i, {pwm_out, cycle_start, busy, cfg_err},
                     {m_busy && (m_pos < m_h), m_cs, m_busy, m_err});
         end
      end
      total++;
      if (highs != 0 || starts != 3) begin
         bad++;
         $display("FAIL reset_mid_shadow_default: got highs=%0d starts=%0d want 0 3", highs, starts);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         if (enable) begin
            if ($urandom_range(11) == 0) enable = 1'b0;
         end else begin
            if ($urandom_range(3) == 0) enable = 1'b1;
         end
         load = ($urandom_range(9) == 0);
         period_in = $urandom_range(12);
         high_in = $urandom_range(14);
`ifdef PWM_GEN_BURST_EN
         burst_len = $urandom_range(3);
`endif
         step();
         total++;
         if ({pwm_out, cycle_start, busy, cfg_err} !== {m_busy && (m_pos < m_h), m_cs, m_busy, m_err}) begin
            bad++;
            $display("FAIL random_cycle %0d: got %b want %b", i, {pwm_out, cycle_start, busy, cfg_err},
                     {m_busy && (m_pos < m_h), m_cs, m_busy, m_err});
         end
`ifdef PWM_GEN_BURST_EN
         total++;
         if (burst_done !== m_done) begin
            bad++;
            $display("FAIL random_burst_done %0d: got %b want %b", i, burst_done, m_done);
         end
`endif
      end
      load = 1'b0;
   endtask

`ifdef PWM_GEN_BURST_EN
   task automatic test_burst();
      int k, pulses, dones;
      logic prev;
      k = 0; pulses = 0; dones = 0; prev = 1'b0;
      enable = 1'b0;
      while (busy === 1'b1 && k < 40) begin
         step();
         k++;
      end
      step();
      burst_len = 3; period_in = 5; high_in = 2; load = 1'b1; step(); load = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (pwm_out === 1'b1 && prev === 1'b0) pulses++;
         prev = pwm_out;
         dones += int'(burst_done);
         total++;
         if ({pwm_out, cycle_start, busy, burst_done} !== {m_busy && (m_pos < m_h), m_cs, m_busy, m_done}) begin
            bad++;
            $display("FAIL burst_cycle %0d: got %b want %b", i, {pwm_out, cycle_start, busy, burst_done},
                     {m_busy && (m_pos < m_h), m_cs, m_busy, m_done});
         end
      end
      total++;
      if (pulses != 3 || dones != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL burst_summary: got pulses=%0d dones=%0d busy=%b want 3 1 0", pulses, dones, busy);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_reload();
      test_edge_high();
      test_cfg_err();
      test_stop();
      test_reset_mid();
      test_random();
`ifdef PWM_GEN_BURST_EN
      test_burst();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
